// File: rtl/conv_pkg.sv
// Shared constants, state encoding and helpers for the convolution front end
package conv_pkg;

   localparam int unsigned K_DIM  = 5;
   localparam int unsigned K_SIZE = K_DIM * K_DIM;
   localparam int unsigned ADDR_W = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      STREAM = 3'd2,
      FLUSH  = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

   // True when a raster position is the bottom-right corner of a full window
   function automatic logic win_complete(input int unsigned row,
                                         input int unsigned col,
                                         input int unsigned kdim);
      return (row >= kdim - 1) && (col >= kdim - 1);
   endfunction

endpackage

// File: rtl/conv_seq_ctrl_raster_cnt.sv
// Column/row raster counter with enable, clear and last-pixel flag
module raster_cnt #(
   parameter int unsigned W  = 28,
   parameter int unsigned H  = 28,
   parameter int unsigned CW = $clog2(W),
   parameter int unsigned RW = $clog2(H)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_col,
   output logic [RW-1:0] o_row,
   output logic          o_last
);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_col_wrap;
   logic          w_row_wrap;

   assign w_col_wrap = (r_col == CW'(W - 1));
   assign w_row_wrap = (r_row == RW'(H - 1));

   // Advance column on enable; column wrap steps the row, frame end wraps both
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_en) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= w_row_wrap ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Weight-load / pixel-stream sequencer feeding the kernel/input register stage
module conv_seq_ctrl #(
   parameter int unsigned K_DIM  = conv_pkg::K_DIM,
   parameter int unsigned K_SIZE = conv_pkg::K_SIZE,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic                       iStart,
   input  logic                       iW_valid,
   input  logic signed [7:0]          iW,
   output logic                       oW_ready,
   input  logic                       iX_valid,
   input  logic signed [7:0]          iX,
   output logic                       oX_ready,
   output logic                       oWren,
   output logic [conv_pkg::ADDR_W-1:0] oADDR,
   output logic signed [7:0]          oWdata,
   output logic                       oValid,
   output logic signed [7:0]          oXdata,
   output logic                       oWin_valid,
   output logic [$clog2(IMG_H)-1:0]   oRow,
   output logic [$clog2(IMG_W)-1:0]   oCol,
   output logic                       oBusy,
   output logic                       oDone
);
   import conv_pkg::*;

   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned CW = $clog2(IMG_W);

   seq_state_t          r_state;
   logic [ADDR_W-1:0]   r_wcnt;
   logic                r_wren;
   logic [ADDR_W-1:0]   r_addr;
   logic signed [7:0]   r_wdata;
   logic                r_valid;
   logic signed [7:0]   r_xdata;
   logic                r_win_pre;
   logic [RW-1:0]       r_row_pre;
   logic [CW-1:0]       r_col_pre;
   logic                r_win;
   logic [RW-1:0]       r_row;
   logic [CW-1:0]       r_col;
   logic                r_done;

   logic                w_w_acc;
   logic                w_x_acc;
   logic                w_wlast;
   logic                w_in_win;
   logic                w_last;
   logic [RW-1:0]       w_row;
   logic [CW-1:0]       w_col;

   assign oW_ready = (r_state == LOAD_W);
   assign oX_ready = (r_state == STREAM);
   assign w_w_acc  = iW_valid && oW_ready;
   assign w_x_acc  = iX_valid && oX_ready;
   assign w_wlast  = (r_wcnt == ADDR_W'(K_SIZE - 1));
   assign w_in_win = win_complete(32'(w_row), 32'(w_col), K_DIM);

   raster_cnt #(
      .W  (IMG_W),
      .H  (IMG_H),
      .CW (CW),
      .RW (RW)
   ) u_raster (
      .i_clk  (iCLK),
      .i_rst  (iRST),
      .i_clr  (w_w_acc && w_wlast),
      .i_en   (w_x_acc),
      .o_col  (w_col),
      .o_row  (w_row),
      .o_last (w_last)
   );

   // Sequencer FSM with registered strobes; the window flag passes through
   // one extra register so it lines up with the register stage's output
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state   <= IDLE;
         r_wcnt    <= '0;
         r_wren    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_valid   <= 1'b0;
         r_xdata   <= '0;
         r_win_pre <= 1'b0;
         r_row_pre <= '0;
         r_col_pre <= '0;
         r_win     <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_wren    <= 1'b0;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_win_pre <= 1'b0;
         r_win     <= r_win_pre;
         if (r_win_pre) begin
            r_row <= r_row_pre;
            r_col <= r_col_pre;
         end
         unique case (r_state)
            IDLE: begin
               if (iStart) begin
                  r_state <= LOAD_W;
                  r_wcnt  <= '0;
               end
            end
            LOAD_W: begin
               if (w_w_acc) begin
                  r_wren  <= 1'b1;
                  r_addr  <= r_wcnt;
                  r_wdata <= iW;
                  r_wcnt  <= r_wcnt + 1'b1;
                  if (w_wlast) r_state <= STREAM;
               end
            end
            STREAM: begin
               if (w_x_acc) begin
                  r_valid   <= 1'b1;
                  r_xdata   <= iX;
                  r_win_pre <= w_in_win;
                  r_row_pre <= w_row;
                  r_col_pre <= w_col;
                  if (w_last) r_state <= FLUSH;
               end
            end
            FLUSH: begin
               r_state <= DONE;
               r_done  <= 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign oWren      = r_wren;
   assign oADDR      = r_addr;
   assign oWdata     = r_wdata;
   assign oValid     = r_valid;
   assign oXdata     = r_xdata;
   assign oWin_valid = r_win;
   assign oRow       = r_row;
   assign oCol       = r_col;
   assign oBusy      = (r_state != IDLE);
   assign oDone      = r_done;

endmodule
